// File: rtl/float_to_fixed_pipe_if.sv
// Valid/ready stream carrying IEEE-754 singles in and signed fixed-point results out.
interface float_to_fixed_pipe_if #(
    parameter int OUT_WIDTH = 32
);
    logic                 i_VALID;
    logic                 o_READY;
    logic [31:0]          i_FLOAT_WORD;
    logic                 o_VALID;
    logic                 i_READY;
    logic [OUT_WIDTH-1:0] o_FIXED_RESULT;
    logic                 o_OVF;
    logic                 o_NAN;
    logic                 o_INEXACT;

    modport master (
        output i_VALID, i_FLOAT_WORD, i_READY,
        input  o_READY, o_VALID, o_FIXED_RESULT, o_OVF, o_NAN, o_INEXACT
    );

    modport slave (
        input  i_VALID, i_FLOAT_WORD, i_READY,
        output o_READY, o_VALID, o_FIXED_RESULT, o_OVF, o_NAN, o_INEXACT
    );
endinterface

// File: rtl/float_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed Q-format converter with saturation,
// selectable truncate/RNE rounding, and a stall-everything valid/ready pipeline.
module float_to_fixed_pipe #(
    parameter int OUT_WIDTH  = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ROUND_MODE = 1
) (
    input logic i_CLK,
    input logic i_RST,
    float_to_fixed_pipe_if.slave bus
);
    localparam int XW = OUT_WIDTH + 26;
    localparam int SW = $clog2(XW);
    localparam logic signed [10:0] P_MAX = 11'(OUT_WIDTH - 1);
    localparam logic signed [10:0] P_MIN = -11'sd1;
    localparam logic [OUT_WIDTH:0]   HALF = (OUT_WIDTH + 1)'(1) << (OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] MAXV = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MINV = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic stall, advance;
    assign stall       = bus.o_VALID & ~bus.i_READY;
    assign advance     = ~stall;
    assign bus.o_READY = advance;

    // S1: unpack and classify; p1 is the bit position of the leading one in the result
    logic                   v1, sign1, zero1, special1, frac_nz1;
    logic signed [10:0]     p1;
    logic [23:0]            m1;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            v1 <= 1'b0;
        end else if (advance) begin
            v1       <= bus.i_VALID;
            sign1    <= bus.i_FLOAT_WORD[31];
            zero1    <= (bus.i_FLOAT_WORD[30:23] == 8'h00);
            special1 <= (bus.i_FLOAT_WORD[30:23] == 8'hFF);
            frac_nz1 <= (bus.i_FLOAT_WORD[22:0] != 23'd0);
            m1       <= {1'b1, bus.i_FLOAT_WORD[22:0]};
            p1       <= $signed({3'b000, bus.i_FLOAT_WORD[30:23]}) - 11'sd127 + 11'(FRAC_BITS);
        end
    end

    // S2: align mantissa so bit 26 is the result LSB, bits 25/24 guard/round, rest sticky
    logic              in_range;
    logic [SW-1:0]     amt;
    logic [XW-1:0]     x;

    always_comb begin
        in_range = (p1 >= P_MIN) && (p1 <= P_MAX);
        amt      = in_range ? SW'(p1 + 11'sd3) : '0;
        x        = XW'(m1) << amt;
    end

    logic                 v2, sign2, nan2, sat2, zero2, zinex2, g2, r2, s2;
    logic [OUT_WIDTH-1:0] mag2;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            v2 <= 1'b0;
        end else if (advance) begin
            v2     <= v1;
            sign2  <= sign1;
            nan2   <= special1 & frac_nz1;
            sat2   <= (special1 & ~frac_nz1) | (~special1 & ~zero1 & (p1 > P_MAX));
            zero2  <= ~special1 & (zero1 | (p1 < P_MIN));
            zinex2 <= zero1 ? frac_nz1 : 1'b1;
            mag2   <= x[XW-1:26];
            g2     <= x[25];
            r2     <= x[24];
            s2     <= |x[23:0];
        end
    end

    // S3: round magnitude, saturate, then apply sign
    logic                 inc, inexact_n, ovf_n, nan_n, inx_n;
    logic [OUT_WIDTH:0]   mag_r;
    logic [OUT_WIDTH-1:0] res_n;

    always_comb begin
        inc       = (ROUND_MODE == 1) && g2 && (r2 | s2 | mag2[0]);
        mag_r     = {1'b0, mag2} + (OUT_WIDTH + 1)'(inc);
        inexact_n = g2 | r2 | s2;
        res_n     = '0;
        ovf_n     = 1'b0;
        nan_n     = 1'b0;
        inx_n     = 1'b0;
        if (!v2) begin
            res_n = '0;
        end else if (nan2) begin
            nan_n = 1'b1;
        end else if (sat2) begin
            res_n = sign2 ? MINV : MAXV;
            ovf_n = 1'b1;
        end else if (zero2) begin
            inx_n = zinex2;
        end else if (mag_r >= HALF) begin
            if (sign2 && (mag_r == HALF)) begin
                res_n = MINV;
                inx_n = inexact_n;
            end else begin
                res_n = sign2 ? MINV : MAXV;
                ovf_n = 1'b1;
            end
        end else begin
            res_n = sign2 ? -mag_r[OUT_WIDTH-1:0] : mag_r[OUT_WIDTH-1:0];
            inx_n = inexact_n;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            bus.o_VALID        <= 1'b0;
            bus.o_FIXED_RESULT <= '0;
            bus.o_OVF          <= 1'b0;
            bus.o_NAN          <= 1'b0;
            bus.o_INEXACT      <= 1'b0;
        end else if (advance) begin
            bus.o_VALID        <= v2;
            bus.o_FIXED_RESULT <= res_n;
            bus.o_OVF          <= ovf_n;
            bus.o_NAN          <= nan_n;
            bus.o_INEXACT      <= inx_n;
        end
    end
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Bench for float_to_fixed_pipe: RNE and truncating instances driven in lockstep,
// checked against a real-arithmetic reference model and spot values.
module tb_float_to_fixed_pipe;
    logic        clk = 1'b0;
    logic        rst, valid, rdy;
    logic [31:0] word;

    always #5 clk = ~clk;

    float_to_fixed_pipe_if #(.OUT_WIDTH(32)) bus_r ();
    float_to_fixed_pipe_if #(.OUT_WIDTH(32)) bus_t ();

    assign bus_r.i_VALID      = valid;
    assign bus_r.i_FLOAT_WORD = word;
    assign bus_r.i_READY      = rdy;
    assign bus_t.i_VALID      = valid;
    assign bus_t.i_FLOAT_WORD = word;
    assign bus_t.i_READY      = rdy;

    float_to_fixed_pipe #(.OUT_WIDTH(32), .FRAC_BITS(16), .ROUND_MODE(1)) dut_rne (
        .i_CLK(clk), .i_RST(rst), .bus(bus_r)
    );
    float_to_fixed_pipe #(.OUT_WIDTH(32), .FRAC_BITS(16), .ROUND_MODE(0)) dut_trunc (
        .i_CLK(clk), .i_RST(rst), .bus(bus_t)
    );

    typedef struct packed {
        logic [31:0] res_r;
        logic [2:0]  fl_r;
        logic [31:0] res_t;
        logic [2:0]  fl_t;
    } exp_t;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] rr;
        logic [31:0] rt;
        logic [2:0]  fl;
    } dir_t;

    // flags packed as {ovf, nan, inexact}
    localparam dir_t DIRS [12] = '{
        '{32'h3FC00000, 32'h00018000, 32'h00018000, 3'b000},
        '{32'hC0300000, 32'hFFFD4000, 32'hFFFD4000, 3'b000},
        '{32'h47000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b100},
        '{32'hC7000000, 32'h80000000, 32'h80000000, 3'b000},
        '{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b100},
        '{32'hFF800000, 32'h80000000, 32'h80000000, 3'b100},
        '{32'h37C00000, 32'h00000002, 32'h00000001, 3'b001},
        '{32'h38200000, 32'h00000002, 32'h00000002, 3'b001},
        '{32'h7FC00000, 32'h00000000, 32'h00000000, 3'b010},
        '{32'h00000001, 32'h00000000, 32'h00000000, 3'b001},
        '{32'h80000000, 32'h00000000, 32'h00000000, 3'b000},
        '{32'h33000000, 32'h00000000, 32'h00000000, 3'b001}
    };

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, acc_cyc = 0, first_v_cyc = -1, acc0 = 0, n = 0;
    bit   accepted = 1'b0, use_fixed = 1'b0;
    exp_t fixed_exp;
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Value = float * 2^16 computed in real arithmetic (exact for these ranges)
    function automatic void ref_model(input logic [31:0] w, input bit rne,
                                      output logic [31:0] res, output logic [2:0] fl);
        logic [7:0]  ex;
        logic [22:0] fr;
        bit          neg, inexact;
        real         mag, fpart;
        longint      ip;
        int          k;
        ex  = w[30:23];
        fr  = w[22:0];
        neg = w[31];
        res = '0;
        fl  = '0;
        if (ex == 8'hFF && fr != 23'd0) begin
            fl = 3'b010;
            return;
        end
        if (ex == 8'hFF) begin
            res = neg ? 32'h80000000 : 32'h7FFFFFFF;
            fl  = 3'b100;
            return;
        end
        if (ex == 8'h00) begin
            fl = {2'b00, fr != 23'd0};
            return;
        end
        mag = real'({1'b1, fr});
        k   = int'(ex) - 150 + 16;
        if (k > 0) for (int i = 0; i < k; i++) mag = mag * 2.0;
        else       for (int i = 0; i < -k; i++) mag = mag / 2.0;
        if (mag >= 4294967296.0) begin
            res = neg ? 32'h80000000 : 32'h7FFFFFFF;
            fl  = 3'b100;
            return;
        end
        ip      = longint'($floor(mag));
        fpart   = mag - real'(ip);
        inexact = (fpart != 0.0);
        if (rne && (fpart > 0.5 || (fpart == 0.5 && ip[0]))) ip = ip + 1;
        if (ip >= 64'sd2147483648) begin
            if (neg && ip == 64'sd2147483648) begin
                res = 32'h80000000;
                fl  = {2'b00, inexact};
            end else begin
                res = neg ? 32'h80000000 : 32'h7FFFFFFF;
                fl  = 3'b100;
            end
            return;
        end
        res = neg ? 32'(-ip) : 32'(ip);
        fl  = {2'b00, inexact};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 9))
            0: w = 32'h7F800000;
            1: w = 32'hFF800000;
            2: w = 32'h7FC00000 | 32'($urandom_range(0, 255));
            3: w = 32'($urandom_range(0, 1)) << 31 | 32'($urandom_range(0, 8));
            4: w = 32'hC7000000;
            default: w = {1'($urandom_range(0, 1)), 8'($urandom_range(104, 146)), 23'($urandom)};
        endcase
        return w;
    endfunction

    // One clock: check outputs mid-cycle, record acceptance, return #1 after the edge
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("ready_rne", bus_r.o_READY, !(bus_r.o_VALID && !rdy));
        chk("ready_trunc", bus_t.o_READY, !(bus_t.o_VALID && !rdy));
        if (bus_r.o_VALID && first_v_cyc < 0) first_v_cyc = cyc;
        if (bus_r.o_VALID) begin
            if (rdy) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", bus_r.o_VALID, 0);
                end else begin
                    e = q.pop_front();
                    chk("res_rne", bus_r.o_FIXED_RESULT, e.res_r);
                    chk("flags_rne", {bus_r.o_OVF, bus_r.o_NAN, bus_r.o_INEXACT}, e.fl_r);
                    chk("valid_trunc", bus_t.o_VALID, 1);
                    chk("res_trunc", bus_t.o_FIXED_RESULT, e.res_t);
                    chk("flags_trunc", {bus_t.o_OVF, bus_t.o_NAN, bus_t.o_INEXACT}, e.fl_t);
                end
            end
        end else begin
            chk("idle_zero_rne", {bus_r.o_FIXED_RESULT, bus_r.o_OVF, bus_r.o_NAN, bus_r.o_INEXACT}, 0);
        end
        accepted = 1'b0;
        if (valid && bus_r.o_READY) begin
            if (use_fixed) e = fixed_exp;
            else begin
                ref_model(word, 1'b1, e.res_r, e.fl_r);
                ref_model(word, 1'b0, e.res_t, e.fl_t);
            end
            q.push_back(e);
            accepted = 1'b1;
            acc_cyc  = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        valid = 1'b1;
        word  = w;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (accepted) break;
        end
        chk("send_accepted", accepted, 1);
        valid = 1'b0;
    endtask

    task automatic drain();
        valid = 1'b0;
        rdy   = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        rdy   = 1'b1;
        word  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus_r.o_VALID, 0);
        chk("rst_ready", bus_r.o_READY, 1);
        chk("rst_outputs", {bus_r.o_FIXED_RESULT, bus_r.o_OVF, bus_r.o_NAN, bus_r.o_INEXACT}, 0);
        chk("rst_outputs_trunc", {bus_t.o_FIXED_RESULT, bus_t.o_VALID, bus_t.o_OVF, bus_t.o_NAN, bus_t.o_INEXACT}, 0);
        @(posedge clk);
        #1;

        use_fixed = 1'b1;
        for (int d = 0; d < 12; d++) begin
            fixed_exp = '{DIRS[d].rr, DIRS[d].fl, DIRS[d].rt, DIRS[d].fl};
            first_v_cyc = -1;
            send(DIRS[d].w);
            acc0 = acc_cyc;
            drain();
            if (d == 0) chk("latency", 64'(first_v_cyc - acc0), 3);
        end
        use_fixed = 1'b0;

        valid = 1'b1;
        word  = rand_word();
        n     = 0;
        for (int c = 0; c < 200 && n < 8; c++) begin
            rdy = pat[c % 4];
            cycle();
            if (accepted) begin
                n++;
                word = rand_word();
            end
        end
        valid = 1'b0;
        chk("stream_sent", n, 8);
        drain();

        accepted = 1'b1;
        valid    = 1'b0;
        for (int c = 0; c < 120; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if (!valid || accepted) begin
                valid = ($urandom_range(0, 3) != 0);
                word  = rand_word();
            end
            cycle();
        end
        drain();

        rdy   = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word = rand_word();
            cycle();
            chk("inflight_accept", accepted, 1);
        end
        valid = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_valid", bus_r.o_VALID, 0);
        chk("midrst_ready", bus_r.o_READY, 1);
        chk("midrst_outputs", {bus_r.o_FIXED_RESULT, bus_r.o_OVF, bus_r.o_NAN, bus_r.o_INEXACT}, 0);
        chk("midrst_valid_trunc", bus_t.o_VALID, 0);
        @(posedge clk);
        #1;
        rdy = 1'b1;
        repeat (8) cycle();
        send(32'h3FC00000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
